// File: rtl/multi_phase_signal_ctrl.sv
// rtl/multi_phase_signal_ctrl.sv - N-phase demand-driven intersection signal controller
// Phase 0 rests in green; side phases are served cyclically on demand; hold forces all-red.
module multi_phase_signal_ctrl #(
   parameter int  NUM_PHASES   = 4,
   parameter int  CNT_W        = 10,
   parameter int  DEMAND_W     = 7,
   parameter int  MIN_GREEN    = 120,
   parameter int  EXT_STEP     = 40,
   parameter int  MAX_GREEN    = 750,
   parameter int  YELLOW_T     = 30,
   parameter int  ALLRED_T     = 5,
   parameter int  HEAVY_THRESH = 30,
   localparam int PW           = $clog2(NUM_PHASES)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_PHASES-1:0]   arrive,
   input  logic [4:0]              light_rank,
   input  logic                    hold,
   output logic [2*NUM_PHASES-1:0] light,
   output logic [PW-1:0]           cur_phase,
   output logic                    phase_start,
   output logic [DEMAND_W-1:0]     served_cnt
);
   localparam logic [1:0] S_GREEN  = 2'd0;
   localparam logic [1:0] S_YELLOW = 2'd1;
   localparam logic [1:0] S_ALLRED = 2'd2;
   localparam int WW        = CNT_W + 6;
   localparam int LW        = 2 * NUM_PHASES;
   localparam int HEAVY_DUR = (2 * MIN_GREEN > MAX_GREEN) ? MAX_GREEN : 2 * MIN_GREEN;
   localparam logic [DEMAND_W-1:0] DEM_MAX = '1;

   logic [1:0]          state, next_state;
   logic [CNT_W-1:0]    cnt, green_dur, dur0;
   logic [WW-1:0]       ext_sum;
   logic [DEMAND_W-1:0] demand [NUM_PHASES];
   logic [4:0]          rank_q;
   logic                init_q, heavy_q, hold_flag;
   logic                side_demand, green_expired, enter, found;
   logic [PW-1:0]       next_phase, sel_phase;
   logic [LW-1:0]       light_next;
   int                  sel_idx;

   assign ext_sum       = WW'(MIN_GREEN) + WW'(EXT_STEP) * WW'(rank_q);
   assign dur0          = (ext_sum > WW'(MAX_GREEN)) ? CNT_W'(MAX_GREEN) : ext_sum[CNT_W-1:0];
   assign green_dur     = (cur_phase == '0) ? dur0 :
                          (heavy_q ? CNT_W'(HEAVY_DUR) : CNT_W'(MIN_GREEN));
   assign green_expired = (cnt >= green_dur - CNT_W'(1));

   always_comb begin
      side_demand = 1'b0;
      for (int k = 1; k < NUM_PHASES; k++)
         if (demand[k] != '0) side_demand = 1'b1;
   end

   // Phase 0 is treated as always demanding, so the search always terminates on it at the latest.
   always_comb begin
      sel_phase = '0;
      sel_idx   = 0;
      found     = hold_flag;
      for (int i = 1; i <= NUM_PHASES; i++) begin
         sel_idx = (int'(cur_phase) + i) % NUM_PHASES;
         if (!found && (sel_idx == 0 || demand[PW'(sel_idx)] != '0)) begin
            sel_phase = PW'(sel_idx);
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_phase = cur_phase;
      enter      = 1'b0;
      case (state)
         S_GREEN:
            if (hold || (green_expired && (cur_phase != '0 || side_demand)))
               next_state = S_YELLOW;
         S_YELLOW:
            if (cnt == CNT_W'(YELLOW_T - 1)) next_state = S_ALLRED;
         S_ALLRED:
            if (!hold && cnt == CNT_W'(ALLRED_T - 1)) begin
               next_state = S_GREEN;
               next_phase = sel_phase;
               enter      = 1'b1;
            end
         default: next_state = S_GREEN;
      endcase
   end

   always_comb begin
      light_next = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (PW'(k) == next_phase) begin
            if (next_state == S_GREEN)       light_next[2*k +: 2] = 2'b01;
            else if (next_state == S_YELLOW) light_next[2*k +: 2] = 2'b10;
         end
      end
   end

   // init_q lets the post-reset green pick up the live rank on the first active edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_GREEN;
         cur_phase   <= '0;
         cnt         <= '0;
         rank_q      <= '0;
         init_q      <= 1'b1;
         heavy_q     <= 1'b0;
         hold_flag   <= 1'b0;
         light       <= LW'(1);
         phase_start <= 1'b0;
         served_cnt  <= '0;
      end else begin
         state       <= next_state;
         cur_phase   <= next_phase;
         light       <= light_next;
         phase_start <= enter;
         init_q      <= 1'b0;
         if (next_state != state || (state == S_ALLRED && hold))
            cnt <= '0;
         else if (!(state == S_GREEN && green_expired))
            cnt <= cnt + CNT_W'(1);
         if (enter) begin
            served_cnt <= demand[sel_phase];
            heavy_q    <= (int'(demand[sel_phase]) > HEAVY_THRESH);
            hold_flag  <= 1'b0;
         end else if (hold) begin
            hold_flag  <= 1'b1;
         end
         if (init_q || (enter && sel_phase == '0))
            rank_q <= light_rank;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_PHASES; k++) demand[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_PHASES; k++) begin
            if (enter && sel_phase == PW'(k))
               demand[k] <= '0;
            else if (arrive[k] && !(state != S_ALLRED && cur_phase == PW'(k)) && demand[k] != DEM_MAX)
               demand[k] <= demand[k] + DEMAND_W'(1);
         end
      end
   end
endmodule
